// File: rtl/axi_tb_pkg.sv
// Shared types and helpers for the AXI master write-data generator.
//
// Contents:
//   cmd_t             - one queued AW command {id, len, size, addr_lo}, sized
//                       for the widest supported configuration
//   LFSR_POLY_MASK    - Galois feedback mask for x^32+x^22+x^2+x+1
//   LFSR_DEFAULT_SEED - default PRBS reset value
//   lfsr_next()       - one step of the right-shifting Galois LFSR
//   wstrb_calc()      - byte-strobe vector for a given beat of a burst
package axi_tb_pkg;

  // Widest configuration: 1024-bit bus -> 128 lanes -> 7 address bits.
  // IDs wider than CMD_ID_MAX_W are not supported.
  localparam int unsigned CMD_ID_MAX_W  = 32;
  localparam int unsigned ADDR_LO_MAX_W = 7;
  localparam int unsigned STRB_MAX_W    = 128;

  // Right-shift Galois form: taps at x^32, x^22, x^2, x^1 map to bits 31,21,1,0.
  localparam logic [31:0] LFSR_POLY_MASK    = 32'h8020_0003;
  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;

  localparam logic [STRB_MAX_W-1:0] STRB_ONE = {{(STRB_MAX_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [CMD_ID_MAX_W-1:0]  id;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [ADDR_LO_MAX_W-1:0] addr_lo;
  } cmd_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY_MASK) : (s >> 1);
  endfunction

  // Strobe for beat 'beat' of a burst on a bus of 2**strb_lg2 byte lanes.
  // Oversized 'size' values are clamped to the full bus width.
  // Beat 0 strobes from the start lane up to the end of its aligned
  // container; later beats strobe a whole aligned container.
  function automatic logic [STRB_MAX_W-1:0] wstrb_calc(
    input int unsigned              strb_lg2,
    input logic [2:0]               size,
    input logic [ADDR_LO_MAX_W-1:0] addr_lo,
    input logic [7:0]               beat
  );
    int unsigned strb_w;
    int unsigned sz;
    int unsigned bytes;
    int unsigned first;
    int unsigned lane;
    int unsigned base;
    logic [STRB_MAX_W-1:0] strb;
    strb_w = 32'd1 << strb_lg2;
    sz     = (32'(size) > strb_lg2) ? strb_lg2 : 32'(size);
    bytes  = 32'd1 << sz;
    first  = 32'(addr_lo) & (strb_w - 32'd1);
    lane   = (first + 32'(beat) * bytes) & (strb_w - 32'd1);
    base   = lane & ~(bytes - 32'd1);
    strb   = '0;
    for (int unsigned i = 0; i < STRB_MAX_W; i++) begin
      if ((i >= base) && (i < base + bytes) && ((beat != 8'd0) || (i >= first))) begin
        strb = strb | (STRB_ONE << i);
      end
    end
    return strb;
  endfunction

endpackage

// File: rtl/axi_tb_cmd_fifo.sv
// Show-ahead command FIFO.
//
// Ports:
//   aclk, aresetn - clock, asynchronous active-low reset
//   push_i/wdata_i - write request and data; ignored when full unless a pop
//                    happens in the same cycle
//   pop_i          - consume the head entry (ignored when empty)
//   rdata_o        - current head entry (valid while !empty_o)
//   count_o        - number of stored entries (0..DEPTH)
//   full_o/empty_o - occupancy flags, combinational from count
module axi_tb_cmd_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot wr_ptr points at, so the write lands safely after the head is read.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/axi_mst_wgen.sv
// AXI master write-data generator.
//
// Queues every observed AW handshake and plays one W burst per command, in
// AW order, with address/size-aware strobes and PRBS payload. Tracks B
// responses against completed bursts and flags protocol anomalies.
//
// Ports:
//   aclk, aresetn                    - clock, asynchronous active-low reset
//   in_aw*                           - observed AW channel (command push)
//   out_wvalid/in_wready, out_wlast,
//   out_wid, out_wdata, out_wstrb    - W channel driven to the slave port
//   in_bvalid/out_bready, in_bid,
//   in_bresp                         - B channel
//   out_ostd_full                    - command FIFO full
//   out_b_pend                       - bursts completed awaiting B (saturating)
//   out_err                          - sticky {b_slverr, b_unexp, size_err, cmd_ovf}
module axi_mst_wgen
  import axi_tb_pkg::*;
#(
  parameter  int unsigned AXI_ID_W        = 4,
  parameter  int unsigned AXI_DATA_W      = 32,
  parameter  int unsigned AXI_STRB_W      = AXI_DATA_W / 8,
  parameter  int unsigned MST_OSTDREQ_NUM = 4,
  parameter  logic [31:0] PRBS_SEED       = LFSR_DEFAULT_SEED,
  parameter  int unsigned BREADY_MODE     = 0,
  localparam int unsigned STRB_LG2        = $clog2(AXI_STRB_W),
  localparam int unsigned LO_W            = (STRB_LG2 > 0) ? STRB_LG2 : 1,
  localparam int unsigned BPEND_W         = $clog2(MST_OSTDREQ_NUM) + 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  in_awvalid,
  input  logic                  in_awready,
  input  logic [AXI_ID_W-1:0]   in_awid,
  input  logic [7:0]            in_awlen,
  input  logic [2:0]            in_awsize,
  input  logic [LO_W-1:0]       in_awaddr_lo,
  output logic                  out_wvalid,
  input  logic                  in_wready,
  output logic                  out_wlast,
  output logic [AXI_ID_W-1:0]   out_wid,
  output logic [AXI_DATA_W-1:0] out_wdata,
  output logic [AXI_STRB_W-1:0] out_wstrb,
  input  logic                  in_bvalid,
  input  logic [AXI_ID_W-1:0]   in_bid,
  input  logic [1:0]            in_bresp,
  output logic                  out_bready,
  output logic                  out_ostd_full,
  output logic [BPEND_W-1:0]    out_b_pend,
  output logic [3:0]            out_err
);

  localparam int unsigned CMD_W = AXI_ID_W + 8 + 3 + LO_W;
  localparam int unsigned CNT_W = $clog2(MST_OSTDREQ_NUM) + 1;
  localparam logic [BPEND_W-1:0] BPEND_MAX = '1;
  localparam logic BREADY_RST = (BREADY_MODE == 0) ? 1'b1 : 1'b0;

  localparam int ERR_OVF    = 0;
  localparam int ERR_SIZE   = 1;
  localparam int ERR_UNEXP  = 2;
  localparam int ERR_SLVERR = 3;

  // Command FIFO
  logic [CMD_W-1:0]    push_data, head_data;
  logic                push, pop;
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [AXI_ID_W-1:0] head_id;
  logic [7:0]          head_len;
  logic [2:0]          head_size;
  logic [LO_W-1:0]     head_lo;
  cmd_t                head_cmd;

  // Burst / data / response state
  logic [7:0]            beat_q, beat_d;
  logic [31:0]           lfsr_q, lfsr_d;
  logic                  bready_q, bready_d;
  logic [BPEND_W-1:0]    b_pend_q, b_pend_d;
  logic [3:0]            err_q, err_d;

  logic                  wvalid, wlast, w_hs, w_last_hs;
  logic                  b_hs, b_dec, size_bad;
  logic [STRB_MAX_W-1:0] strb_wide;
  logic [AXI_STRB_W-1:0] strb;
  logic                  unused_sink;

  assign push      = in_awvalid && in_awready;
  assign push_data = {in_awid, in_awlen, in_awsize, in_awaddr_lo};

  axi_tb_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (MST_OSTDREQ_NUM)
  ) u_cmd_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (head_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {head_id, head_len, head_size, head_lo} = head_data;

  always_comb begin
    head_cmd         = '0;
    head_cmd.id      = CMD_ID_MAX_W'(head_id);
    head_cmd.len     = head_len;
    head_cmd.size    = head_size;
    head_cmd.addr_lo = ADDR_LO_MAX_W'(head_lo);
  end

  // W handshake bookkeeping. The head entry, beat counter and LFSR only move
  // on a handshake, which keeps the whole payload stable during a stall.
  assign wvalid    = !fifo_empty;
  assign wlast     = wvalid && (beat_q == head_len);
  assign w_hs      = wvalid && in_wready;
  assign w_last_hs = w_hs && wlast;
  assign pop       = w_last_hs;

  assign b_hs     = in_bvalid && bready_q;
  assign b_dec    = b_hs && (b_pend_q != '0);
  assign size_bad = wvalid && (32'(head_size) > STRB_LG2);

  assign strb_wide = wstrb_calc(STRB_LG2, head_cmd.size, head_cmd.addr_lo, beat_q);
  assign strb      = wvalid ? strb_wide[AXI_STRB_W-1:0] : '0;

  // Each byte lane carries the LFSR byte for (lane mod 4); unstrobed lanes
  // are zeroed so downstream checkers never see stale data.
  for (genvar gi = 0; gi < AXI_STRB_W; gi++) begin : g_lane
    assign out_wdata[8*gi +: 8] = strb[gi] ? lfsr_q[8*(gi%4) +: 8] : 8'h00;
  end

  always_comb begin
    beat_d   = beat_q;
    lfsr_d   = lfsr_q;
    bready_d = BREADY_RST;
    b_pend_d = b_pend_q;
    err_d    = err_q;

    if (w_hs) begin
      lfsr_d = lfsr_next(lfsr_q);
      beat_d = wlast ? 8'd0 : (beat_q + 8'd1);
    end

    // Random backpressure on B: sampled every cycle, independent of traffic.
    if (BREADY_MODE == 1) bready_d = lfsr_q[31];

    // Completion and response in the same cycle cancel out.
    if (w_last_hs && !b_dec) begin
      if (b_pend_q != BPEND_MAX) b_pend_d = b_pend_q + 1'b1;
    end else if (!w_last_hs && b_dec) begin
      b_pend_d = b_pend_q - 1'b1;
    end

    if (push && fifo_full && !pop)          err_d[ERR_OVF]    = 1'b1;
    if (size_bad)                           err_d[ERR_SIZE]   = 1'b1;
    if (b_hs && (b_pend_q == '0))           err_d[ERR_UNEXP]  = 1'b1;
    if (b_hs && (in_bresp != 2'b00))        err_d[ERR_SLVERR] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_q   <= '0;
      lfsr_q   <= PRBS_SEED;
      bready_q <= BREADY_RST;
      b_pend_q <= '0;
      err_q    <= '0;
    end else begin
      beat_q   <= beat_d;
      lfsr_q   <= lfsr_d;
      bready_q <= bready_d;
      b_pend_q <= b_pend_d;
      err_q    <= err_d;
    end
  end

  assign out_wvalid    = wvalid;
  assign out_wlast     = wlast;
  assign out_wid       = wvalid ? head_id : '0;
  assign out_wstrb     = strb;
  assign out_bready    = bready_q;
  assign out_ostd_full = fifo_full;
  assign out_b_pend    = b_pend_q;
  assign out_err       = err_q;

  // in_bid is for external monitors only; the wide strobe and head struct
  // are only partly consumed for narrow buses. fifo_count is informational.
  assign unused_sink = ^{in_bid, strb_wide, head_cmd, fifo_count, lfsr_q};

endmodule

// File: tb/tb_axi_mst_wgen.sv
// Randomised and directed bench for axi_mst_wgen. Three instances share all
// inputs: a 32-bit bus, a 64-bit bus, and a 32-bit bus with LFSR-driven
// bready (only its W channel and bready are compared). A queue-based model
// predicts every output each cycle.
module tb_axi_mst_wgen;

  localparam int DEPTH     = 4;
  localparam int BP_W      = $clog2(DEPTH) + 2;
  localparam int BPEND_SAT = (1 << BP_W) - 1;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic       awvalid, awready;
  logic [3:0] awid;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [2:0] awlo;
  logic       wready, bvalid;
  logic [3:0] bid;
  logic [1:0] bresp;

  logic            w32_valid, w32_last, b32_ready, full32;
  logic [3:0]      w32_id, w32_strb, bpend32, err32;
  logic [31:0]     w32_data;
  logic            w64_valid, w64_last, b64_ready, full64;
  logic [3:0]      w64_id, bpend64, err64;
  logic [7:0]      w64_strb;
  logic [63:0]     w64_data;
  logic            wbr_valid, wbr_last, bbr_ready, fullbr;
  logic [3:0]      wbr_id, wbr_strb, bpendbr, errbr;
  logic [31:0]     wbr_data;

  axi_mst_wgen #(.AXI_ID_W(4), .AXI_DATA_W(32), .MST_OSTDREQ_NUM(DEPTH),
                 .PRBS_SEED(32'h1), .BREADY_MODE(0)) u_dut32 (
    .aclk(aclk), .aresetn(aresetn), .in_awvalid(awvalid), .in_awready(awready),
    .in_awid(awid), .in_awlen(awlen), .in_awsize(awsize), .in_awaddr_lo(awlo[1:0]),
    .out_wvalid(w32_valid), .in_wready(wready), .out_wlast(w32_last), .out_wid(w32_id),
    .out_wdata(w32_data), .out_wstrb(w32_strb), .in_bvalid(bvalid), .in_bid(bid),
    .in_bresp(bresp), .out_bready(b32_ready), .out_ostd_full(full32),
    .out_b_pend(bpend32), .out_err(err32));

  axi_mst_wgen #(.AXI_ID_W(4), .AXI_DATA_W(64), .MST_OSTDREQ_NUM(DEPTH),
                 .PRBS_SEED(32'h1), .BREADY_MODE(0)) u_dut64 (
    .aclk(aclk), .aresetn(aresetn), .in_awvalid(awvalid), .in_awready(awready),
    .in_awid(awid), .in_awlen(awlen), .in_awsize(awsize), .in_awaddr_lo(awlo),
    .out_wvalid(w64_valid), .in_wready(wready), .out_wlast(w64_last), .out_wid(w64_id),
    .out_wdata(w64_data), .out_wstrb(w64_strb), .in_bvalid(bvalid), .in_bid(bid),
    .in_bresp(bresp), .out_bready(b64_ready), .out_ostd_full(full64),
    .out_b_pend(bpend64), .out_err(err64));

  axi_mst_wgen #(.AXI_ID_W(4), .AXI_DATA_W(32), .MST_OSTDREQ_NUM(DEPTH),
                 .PRBS_SEED(32'h1), .BREADY_MODE(1)) u_dutbr (
    .aclk(aclk), .aresetn(aresetn), .in_awvalid(awvalid), .in_awready(awready),
    .in_awid(awid), .in_awlen(awlen), .in_awsize(awsize), .in_awaddr_lo(awlo[1:0]),
    .out_wvalid(wbr_valid), .in_wready(wready), .out_wlast(wbr_last), .out_wid(wbr_id),
    .out_wdata(wbr_data), .out_wstrb(wbr_strb), .in_bvalid(bvalid), .in_bid(bid),
    .in_bresp(bresp), .out_bready(bbr_ready), .out_ostd_full(fullbr),
    .out_b_pend(bpendbr), .out_err(errbr));

  // ---------------- checking ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int id; int len; int size; int lo; } cmd_s;
  cmd_s        q[$];
  int          beat_m, bpend_m;
  logic [31:0] lfsr_m, br_exp;
  logic        ovf_m, unexp_m, slverr_m, szerr32_m, szerr64_m;

  // One step of x^32+x^22+x^2+x+1 in Galois (right-shift) form.
  function automatic logic [31:0] prbs_step(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
    return n;
  endfunction

  // Strobe from AXI byte addressing: beat 0 starts at the start address and
  // ends at its container boundary; later beats cover whole containers.
  function automatic logic [7:0] exp_strb(input cmd_s c, input int beat, input int w);
    int lg, sz, nb, start, aligned, addr, lane_lo, lane_hi;
    logic [7:0] s;
    lg      = (w == 4) ? 2 : 3;
    sz      = (c.size > lg) ? lg : c.size;
    nb      = 1 << sz;
    start   = c.lo % w;
    aligned = (start / nb) * nb;
    addr    = (beat == 0) ? start : aligned + beat * nb;
    lane_lo = addr % w;
    lane_hi = ((addr / nb) * nb) % w + nb - 1;
    s = '0;
    for (int i = 0; i < w; i++) if (i >= lane_lo && i <= lane_hi) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] exp_data(input logic [7:0] s, input logic [31:0] l, input int w);
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < w; i++) if (s[i]) d[8*i +: 8] = l[8*(i%4) +: 8];
    return d;
  endfunction

  task automatic model_reset();
    q.delete();
    beat_m = 0; bpend_m = 0; lfsr_m = 32'h1; br_exp = 1'b0;
    ovf_m = 0; unexp_m = 0; slverr_m = 0; szerr32_m = 0; szerr64_m = 0;
  endtask

  task automatic model_step();
    bit   aw_hs, w_hs, last, b_hs, dec;
    cmd_s c;
    aw_hs = awvalid && awready;
    w_hs  = (q.size() > 0) && wready;
    last  = w_hs && (beat_m == q[0].len);
    b_hs  = bvalid;
    if (q.size() > 0) begin
      if (q[0].size > 2) szerr32_m = 1;
      if (q[0].size > 3) szerr64_m = 1;
    end
    br_exp = {31'b0, lfsr_m[31]};
    if (w_hs) begin
      lfsr_m = prbs_step(lfsr_m);
      beat_m = last ? 0 : beat_m + 1;
    end
    dec = b_hs && (bpend_m != 0);
    if (b_hs && bpend_m == 0) unexp_m = 1;
    if (b_hs && bresp != 0) slverr_m = 1;
    if (last && !dec) bpend_m = (bpend_m < BPEND_SAT) ? bpend_m + 1 : BPEND_SAT;
    else if (!last && dec) bpend_m = bpend_m - 1;
    c = '{int'(awid), int'(awlen), int'(awsize), int'(awlo)};
    if (last) begin
      $display("burst done id=%0d len=%0d size=%0d lo=%0d t=%0t",
               q[0].id, q[0].len, q[0].size, q[0].lo, $time);
      void'(q.pop_front());
      if (aw_hs) q.push_back(c);
    end else if (aw_hs) begin
      if (q.size() == DEPTH) ovf_m = 1;
      else q.push_back(c);
    end
  endtask

  always @(negedge aclk) begin : monitor
    cmd_s       h;
    logic [7:0] s32, s64;
    bit         ev;
    if (!aresetn) model_reset();
    ev = (q.size() > 0);
    check_val("wvalid32", w32_valid, ev);
    check_val("wvalid64", w64_valid, ev);
    check_val("wvalid_br", wbr_valid, ev);
    check_val("full32", full32, q.size() == DEPTH);
    check_val("full64", full64, q.size() == DEPTH);
    check_val("bpend32", bpend32, bpend_m);
    check_val("bpend64", bpend64, bpend_m);
    check_val("err32", err32, {slverr_m, unexp_m, szerr32_m, ovf_m});
    check_val("err64", err64, {slverr_m, unexp_m, szerr64_m, ovf_m});
    check_val("bready32", b32_ready, 1'b1);
    check_val("bready_lfsr", bbr_ready, br_exp);
    if (ev) begin
      h   = q[0];
      s32 = exp_strb(h, beat_m, 4);
      s64 = exp_strb(h, beat_m, 8);
    end else begin
      h   = '{0, 0, 0, 0};
      s32 = '0;
      s64 = '0;
    end
    check_val("wid32", w32_id, ev ? h.id : 0);
    check_val("wid64", w64_id, ev ? h.id : 0);
    check_val("wlast32", w32_last, ev && (beat_m == h.len));
    check_val("wlast64", w64_last, ev && (beat_m == h.len));
    check_val("wstrb32", w32_strb, s32[3:0]);
    check_val("wstrb64", w64_strb, s64);
    check_val("wdata32", w32_data, exp_data(s32, lfsr_m, 4));
    check_val("wdata64", w64_data, exp_data(s64, lfsr_m, 8));
    check_val("wdata_br", wbr_data, exp_data(s32, lfsr_m, 4));
    if (aresetn) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_aw(input int id, input int len, input int size, input int lo);
    awvalid = 1; awready = 1;
    awid = 4'(id); awlen = 8'(len); awsize = 3'(size); awlo = 3'(lo);
    cycle();
    awvalid = 0; awready = 0;
  endtask

  task automatic send_b(input logic [1:0] resp);
    bvalid = 1; bresp = resp; bid = 4'($urandom);
    cycle();
    bvalid = 0; bresp = 0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin cycle(); n++; end
    check_val("drain_done", q.size(), 0);
  endtask

  task automatic drain_b(input int limit);
    int n = 0;
    bvalid = 1; bresp = 0;
    while (bpend_m != 0 && n < limit) begin cycle(); n++; end
    bvalid = 0;
    check_val("bdrain_done", bpend_m, 0);
  endtask

  task automatic random_wready_until_idle(input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      wready = 1'($urandom_range(0, 1));
      cycle(); n++;
    end
    check_val("stall_drain_done", q.size(), 0);
  endtask

  initial begin
    aresetn = 0; awvalid = 0; awready = 0; awid = 0; awlen = 0; awsize = 0; awlo = 0;
    wready = 0; bvalid = 0; bid = 0; bresp = 0;
    repeat (3) cycle();
    aresetn = 1;
    cycle();

    // Single aligned burst followed by its OKAY response
    wready = 1;
    send_aw(3, 3, 2, 0);
    wait_idle(20);
    send_b(2'b00);
    cycle();

    // Narrow byte burst from lane 1
    send_aw(1, 7, 0, 1);
    wait_idle(20);
    // Unaligned word burst from lane 3
    send_aw(2, 1, 2, 3);
    wait_idle(20);
    drain_b(10);

    // Five back-to-back commands into a 4-deep FIFO with W stalled
    wready = 0;
    for (int k = 0; k < 5; k++) begin
      awvalid = 1; awready = 1; awid = 4'(k + 4); awlen = 0; awsize = 2; awlo = 0;
      cycle();
    end
    awvalid = 0; awready = 0;
    repeat (2) cycle();
    wready = 1;
    wait_idle(20);
    drain_b(10);

    // 16-beat burst under random backpressure
    send_aw(5, 15, 2, 0);
    random_wready_until_idle(200);
    drain_b(10);

    // Oversized beats: size 3 is too wide for 32 bits, size 4 for both buses
    wready = 1;
    send_aw(6, 1, 3, 1);
    send_aw(8, 0, 4, 2);
    wait_idle(20);

    // Random traffic, throttled on model occupancy
    for (int c = 0; c < 300; c++) begin
      wready  = 1'($urandom_range(0, 1));
      awvalid = ($urandom_range(0, 3) == 0);
      awready = (q.size() < DEPTH);
      awid    = 4'($urandom);
      awlen   = 8'($urandom_range(0, 15));
      awsize  = 3'($urandom_range(0, 2));
      awlo    = 3'($urandom);
      bvalid  = (bpend_m > 0) && ($urandom_range(0, 1) == 1);
      bresp   = 0;
      cycle();
    end
    awvalid = 0; awready = 0; bvalid = 0;
    wready = 1;
    wait_idle(400);
    drain_b(20);

    // Longest burst, then pile up completions past the b_pend limit
    send_aw(7, 255, 1, 1);
    wait_idle(300);
    for (int k = 0; k < BPEND_SAT + 2; k++) send_aw(k, 0, 2, 0);
    wait_idle(10);
    drain_b(40);

    // Response with nothing pending, carrying SLVERR
    send_b(2'b10);
    cycle();

    // Reset in the middle of a burst
    send_aw(9, 7, 2, 0);
    repeat (3) cycle();
    aresetn = 0;
    repeat (2) cycle();
    aresetn = 1;
    repeat (3) cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axi_mst_wgen.md
Name: axi_mst_wgen

Overview:
Parametrised AXI master write-data generator for the crossbar testbench. It is the successor to the fixed 32-bit W driver. It queues every accepted AW command in an outstanding FIFO and drives a compliant W burst per command, with size/address-aware strobes and synthesizable PRBS data. It also tracks B responses against completed bursts and sits between the AW stimulus generator and one crossbar slave port.

Parameters:
AXI_ID_W, 4, AW/W/B ID width
AXI_DATA_W, 32, W data width; power of 2, 8..1024
AXI_STRB_W, AXI_DATA_W/8, derived strobe width
MST_OSTDREQ_NUM, 4, command FIFO depth; power of 2, >=2
PRBS_SEED, 32'h0000_0001, LFSR reset value; must be non-zero
BREADY_MODE, 0, 0 = bready tied high, 1 = bready from LFSR bit 31

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
in_awvalid  in  1  AW valid (observed)
in_awready  in  1  AW ready (observed)
in_awid  in  AXI_ID_W  AW id
in_awlen  in  8  beats-1
in_awsize  in  3  bytes/beat = 2**size
in_awaddr_lo  in  clog2(AXI_STRB_W)  low address bits for lane alignment
out_wvalid  out  1  W valid
in_wready  in  1  W ready
out_wlast  out  1  last beat of burst
out_wid  out  AXI_ID_W  id of current burst
out_wdata  out  AXI_DATA_W  beat data
out_wstrb  out  AXI_STRB_W  byte strobes
in_bvalid  in  1  B valid
in_bid  in  AXI_ID_W  B id (carried for monitor use only)
in_bresp  in  2  B response
out_bready  out  1  B ready
out_ostd_full  out  1  command FIFO full; stimulus must drop in_awready
out_b_pend  out  clog2(MST_OSTDREQ_NUM)+2  bursts sent, B not yet received
out_err  out  4  sticky {b_slverr_seen, b_unexp, size_err, cmd_ovf}

Behaviour:
- Reset: all outputs 0 except out_bready, which is 1 when BREADY_MODE=0. FIFO empty, beat counter 0, LFSR=PRBS_SEED, out_err=0. Reset mid-burst abandons the burst with no completion.
- Push: the FIFO stores {id,len,size,addr_lo} on in_awvalid&&in_awready.
  - Push while full and no pop that cycle: command dropped, cmd_ovf set.
  - Push and pop in the same cycle while full: both take effect.
- out_ostd_full = count==MST_OSTDREQ_NUM (combinational from count).
- out_wvalid = FIFO not empty. AW handshake in cycle N with an empty FIFO gives out_wvalid in cycle N+1.
- Payload is stable while out_wvalid && !in_wready. It changes only after a handshake.
- Beat counter is 8 bits and increments on out_wvalid&&in_wready. out_wlast = out_wvalid && beat==head.len.
- On wlast handshake: beat clears, head pops, the next head is presented the following cycle, and wvalid stays high with no bubble if the FIFO is non-empty. len=255 gives 256 beats without wrap error.
- Strobe: B = 2**size, lane = (addr_lo + beat*B) mod AXI_STRB_W.
  - Beat 0 with unaligned addr_lo: strobes lanes addr_lo..(aligned(addr_lo,B)+B-1).
  - Later beats: strobes B lanes starting at aligned(lane,B).
  - Aligned address range wraps within the bus width.
- size > clog2(AXI_STRB_W): size_err set, beat treated as full width.
- Data: 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1.
  - Advances once per W handshake.
  - out_wdata = LFSR value replicated/truncated to AXI_DATA_W, with bytes outside the strobe forced to 0.
- B tracking: out_b_pend increments on W wlast handshake and decrements on in_bvalid&&out_bready. Both in the same cycle leaves it unchanged. It saturates at max.
  - B handshake with b_pend==0: b_unexp set, no decrement.
  - in_bresp!=0 on a B handshake: b_slverr_seen set.
- BREADY_MODE=1: out_bready registered from the LFSR, sampled each cycle regardless of handshakes.
- out_wid = head id. Bursts are issued strictly in AW order; no write interleaving.

Decomposition:
- Package axi_tb_pkg holds:
  - cmd_t struct {id,len,size,addr_lo}
  - LFSR polynomial and default seed constants
  - function wstrb_calc(size,addr_lo,beat) returning the strobe vector, shared with the scoreboard
- One sub-module, axi_tb_cmd_fifo: parametrised width/depth FIFO with count, full, empty and simultaneous push/pop support.

Test Plan:
- Single AW id=3 len=3 size=2 addr_lo=0, wready=1 -> wvalid cycle N+1; 4 beats; wstrb=4'hF each; wlast on beat 3; wid=3; 1 B (bresp=0) -> b_pend 1->0, out_err=0.
- Narrow: DATA_W=32, len=7 size=0 addr_lo=1 -> wstrb sequence 2,4,8,1,2,4,8,1; data bytes outside strobe are 0.
- Unaligned size=2 on DATA_W=64, addr_lo=3, len=1 -> beat0 wstrb=8'h08 (lanes 3 only, container 0..3), beat1 wstrb=8'hF0.
- Back-to-back 5 AW len=0 with FIFO depth 4 and no W drain -> out_ostd_full after 4th push; 5th sets out_err[0]; drain gives 4 wlast with no bubbles.
- Random wready 50%, len=15 -> wdata/wstrb held while stalled; 16 beats; LFSR advances exactly 16 times (matches model from PRBS_SEED).
- B with no pending burst, bresp=2'b10 -> out_err[2] and out_err[3] set; b_pend stays 0; assert aresetn=0 mid-burst -> all outputs and errors back to reset values.
